// File: rtl/multicycle_addsub.sv
// Multi-cycle ripple adder/subtractor: adds CHUNK bits per clock, LSB chunk first,
// with a registered carry between chunks and valid/ready handshakes on both sides.
module multicycle_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
    $error("multicycle_addsub: WIDTH must be a non-zero multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_valid;
  logic             r_in_ready;
  logic             r_busy;

  logic [31:0]      w_base;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_chunk_res;
  logic             w_last;

  function automatic logic [CHUNK:0] f_chunk_add(
    input logic [CHUNK-1:0] x,
    input logic [CHUNK-1:0] y,
    input logic             c
  );
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
  endfunction

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic f_signed_ovf(
    input logic a_msb,
    input logic b_msb,
    input logic s_msb
  );
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign w_base      = 32'(r_idx) * CHUNK;
  assign w_a_chunk   = r_a[w_base +: CHUNK];
  assign w_b_chunk   = r_b[w_base +: CHUNK];
  assign w_chunk_res = f_chunk_add(w_a_chunk, w_b_chunk, r_carry);
  assign w_last      = (r_idx == LAST_IDX);

  // Control FSM plus datapath registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            // Subtraction runs as a + ~b + ~cin, so borrow-in becomes inverted carry-in.
            r_a        <= a;
            r_b        <= sub ? ~b : b;
            r_carry    <= cin ^ sub;
            r_idx      <= '0;
            r_state    <= ST_RUN;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_sum[w_base +: CHUNK] <= w_chunk_res[CHUNK-1:0];
          r_carry                <= w_chunk_res[CHUNK];
          if (w_last) begin
            r_state     <= ST_DONE;
            r_idx       <= '0;
            r_out_valid <= 1'b1;
            r_cout      <= w_chunk_res[CHUNK];
            r_ovf       <= f_signed_ovf(r_a[WIDTH-1], r_b[WIDTH-1], w_chunk_res[CHUNK-1]);
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_idx       <= '0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_multicycle_addsub.sv
// Bench for multicycle_addsub: four parameterisations checked every cycle against an
// arithmetic reference model, plus directed literal vectors.
module tb_multicycle_addsub;

  localparam int MI = 0;
  localparam int MR = 1;
  localparam int MD = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  in_valid_v, sub_v, cin_v, out_ready_v;
  logic [31:0] a_v [4];
  logic [31:0] b_v [4];
  wire  [3:0]  in_ready_w, out_valid_w, cout_w, ovf_w, busy_w;
  wire  [15:0] sum0, sum1, sum2;
  wire  [31:0] sum3;

  int n_vec = 0;
  int n_err = 0;

  multicycle_addsub #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[0]), .in_ready(in_ready_w[0]),
    .a(a_v[0][15:0]), .b(b_v[0][15:0]), .sub(sub_v[0]), .cin(cin_v[0]),
    .out_valid(out_valid_w[0]), .out_ready(out_ready_v[0]), .sum(sum0),
    .cout(cout_w[0]), .ovf(ovf_w[0]), .busy(busy_w[0]));

  multicycle_addsub #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[1]), .in_ready(in_ready_w[1]),
    .a(a_v[1][15:0]), .b(b_v[1][15:0]), .sub(sub_v[1]), .cin(cin_v[1]),
    .out_valid(out_valid_w[1]), .out_ready(out_ready_v[1]), .sum(sum1),
    .cout(cout_w[1]), .ovf(ovf_w[1]), .busy(busy_w[1]));

  multicycle_addsub #(.WIDTH(16), .CHUNK(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[2]), .in_ready(in_ready_w[2]),
    .a(a_v[2][15:0]), .b(b_v[2][15:0]), .sub(sub_v[2]), .cin(cin_v[2]),
    .out_valid(out_valid_w[2]), .out_ready(out_ready_v[2]), .sum(sum2),
    .cout(cout_w[2]), .ovf(ovf_w[2]), .busy(busy_w[2]));

  multicycle_addsub #(.WIDTH(32), .CHUNK(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_v[3]), .in_ready(in_ready_w[3]),
    .a(a_v[3]), .b(b_v[3]), .sub(sub_v[3]), .cin(cin_v[3]),
    .out_valid(out_valid_w[3]), .out_ready(out_ready_v[3]), .sum(sum3),
    .cout(cout_w[3]), .ovf(ovf_w[3]), .busy(busy_w[3]));

  function automatic int wid(input int k);
    return (k == 3) ? 32 : 16;
  endfunction

  function automatic int nch(input int k);
    case (k)
      0:       return 4;
      1:       return 1;
      2:       return 16;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] dut_sum(input int k);
    case (k)
      0:       return {16'h0000, sum0};
      1:       return {16'h0000, sum1};
      2:       return {16'h0000, sum2};
      default: return sum3;
    endcase
  endfunction

  // Reference arithmetic on plain integers: modulo sum, raw carry / no-borrow, signed range overflow.
  function automatic void ref_op(input int w, input logic [31:0] a_in, input logic [31:0] b_in,
                                 input logic s, input logic c, output logic [31:0] rs,
                                 output logic rc, output logic ro);
    longint mask, ua, ub, sa, sb, cc, full, r, lim;
    mask = (longint'(1) << w) - 1;
    ua   = longint'({32'h0, a_in}) & mask;
    ub   = longint'({32'h0, b_in}) & mask;
    cc   = c ? 1 : 0;
    sa   = (((ua >> (w - 1)) & 1) != 0) ? ua - (mask + 1) : ua;
    sb   = (((ub >> (w - 1)) & 1) != 0) ? ub - (mask + 1) : ub;
    lim  = longint'(1) << (w - 1);
    if (!s) begin
      full = ua + ub + cc;
      rc   = (((full >> w) & 1) != 0);
      r    = sa + sb + cc;
    end else begin
      full = ua - ub - cc;
      rc   = (ua >= ub + cc);
      r    = sa - sb - cc;
    end
    rs = 32'(full & mask);
    ro = (r >= lim) || (r < -lim);
  endfunction

  int          m_state [4];
  int          m_cnt   [4];
  bit          m_acc   [4];
  logic [31:0] m_sum   [4];
  logic [31:0] p_sum   [4];
  logic        m_cout  [4];
  logic        m_ovf   [4];
  logic        p_cout  [4];
  logic        p_ovf   [4];

  // Transaction-level model: accept in idle, result visible NCHUNK edges later, held until taken.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 4; k++) begin
      if (!rst_n) begin
        m_state[k] = MI; m_cnt[k] = 0; m_acc[k] = 1'b0;
        m_sum[k] = 32'h0; m_cout[k] = 1'b0; m_ovf[k] = 1'b0;
      end else begin
        m_acc[k] = 1'b0;
        case (m_state[k])
          MI: if (in_valid_v[k]) begin
            ref_op(wid(k), a_v[k], b_v[k], sub_v[k], cin_v[k], p_sum[k], p_cout[k], p_ovf[k]);
            m_state[k] = MR; m_cnt[k] = 0; m_acc[k] = 1'b1;
          end
          MR: begin
            m_cnt[k] = m_cnt[k] + 1;
            if (m_cnt[k] == nch(k)) begin
              m_state[k] = MD;
              m_sum[k] = p_sum[k]; m_cout[k] = p_cout[k]; m_ovf[k] = p_ovf[k];
            end
          end
          MD: if (out_ready_v[k]) m_state[k] = MI;
          default: m_state[k] = MI;
        endcase
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Per-cycle comparison of every instance against the model; sum is skipped mid-run.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      check($sformatf("dut%0d in_ready", k), {31'h0, in_ready_w[k]}, {31'h0, m_state[k] == MI});
      check($sformatf("dut%0d out_valid", k), {31'h0, out_valid_w[k]}, {31'h0, m_state[k] == MD});
      check($sformatf("dut%0d busy", k), {31'h0, busy_w[k]}, {31'h0, m_state[k] != MI});
      if (m_state[k] != MR) begin
        check($sformatf("dut%0d sum", k), dut_sum(k), m_sum[k]);
        check($sformatf("dut%0d cout", k), {31'h0, cout_w[k]}, {31'h0, m_cout[k]});
        check($sformatf("dut%0d ovf", k), {31'h0, ovf_w[k]}, {31'h0, m_ovf[k]});
      end
    end
  end

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic        c;
    logic [31:0] sum;
    logic        co;
    logic        ov;
  } vec_t;

  vec_t vt [6];

  // Launches one op, leaves the result pending in DONE, returns edges from accept to out_valid.
  task automatic run_dir(input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic c, output int lat);
    a_v[k] = a; b_v[k] = b; sub_v[k] = s; cin_v[k] = c;
    in_valid_v[k] = 1'b1; out_ready_v[k] = 1'b0;
    @(posedge clk); #1;
    in_valid_v[k] = 1'b0;
    a_v[k] = $urandom; b_v[k] = $urandom;
    lat = 0;
    while (!out_valid_w[k] && lat < 64) begin
      check($sformatf("dut%0d in_ready while busy", k), {31'h0, in_ready_w[k]}, 32'h0);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_k(input int k);
    out_ready_v[k] = 1'b1;
    @(posedge clk); #1;
    out_ready_v[k] = 1'b0;
    check($sformatf("dut%0d in_ready after take", k), {31'h0, in_ready_w[k]}, 32'h1);
  endtask

  task automatic rand_ops(input int k, input int n);
    int t;
    for (int i = 0; i < n; i++) begin
      a_v[k] = $urandom; b_v[k] = $urandom;
      sub_v[k] = 1'($urandom_range(1, 0)); cin_v[k] = 1'($urandom_range(1, 0));
      in_valid_v[k] = 1'b1;
      @(posedge clk); #1;
      check($sformatf("dut%0d accepted", k), {31'h0, m_acc[k]}, 32'h1);
      t = 0;
      while (m_state[k] != MI && t < 200) begin
        in_valid_v[k] = 1'($urandom_range(1, 0));
        a_v[k] = $urandom;
        out_ready_v[k] = 1'($urandom_range(1, 0));
        @(posedge clk); #1;
        t++;
      end
      if (t >= 200) check($sformatf("dut%0d op timeout", k), 32'(t), 32'd0);
      in_valid_v[k] = 1'b0; out_ready_v[k] = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vt[0] = '{32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vt[1] = '{32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_8000, 1'b0, 1'b1};
    vt[2] = '{32'h0000_1234, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_1236, 1'b0, 1'b0};
    vt[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'h0000_FFFE, 1'b0, 1'b0};
    vt[4] = '{32'h0000_8000, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_7FFF, 1'b1, 1'b1};
    vt[5] = '{32'h0000_0010, 32'h0000_0001, 1'b1, 1'b1, 32'h0000_000E, 1'b1, 1'b0};
    in_valid_v = 4'h0; sub_v = 4'h0; cin_v = 4'h0; out_ready_v = 4'h0;
    for (int k = 0; k < 4; k++) begin a_v[k] = 32'h0; b_v[k] = 32'h0; end

    repeat (2) @(posedge clk);
    #1;
    check("reset sum", dut_sum(0), 32'h0);
    check("reset in_ready", {31'h0, in_ready_w[0]}, 32'h1);
    check("reset out_valid", {31'h0, out_valid_w[0]}, 32'h0);
    check("reset busy", {31'h0, busy_w[0]}, 32'h0);
    check("reset cout", {31'h0, cout_w[0]}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_dir(0, vt[i].a, vt[i].b, vt[i].s, vt[i].c, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d sum", i), dut_sum(0), vt[i].sum);
      check($sformatf("vec%0d cout", i), {31'h0, cout_w[0]}, {31'h0, vt[i].co});
      check($sformatf("vec%0d ovf", i), {31'h0, ovf_w[0]}, {31'h0, vt[i].ov});
      if (i == 1) begin
        for (int j = 0; j < 5; j++) begin
          in_valid_v[0] = (j % 2 == 0);
          a_v[0] = $urandom;
          @(posedge clk); #1;
          check("hold sum", dut_sum(0), 32'h0000_8000);
          check("hold cout", {31'h0, cout_w[0]}, 32'h0);
          check("hold ovf", {31'h0, ovf_w[0]}, 32'h1);
          check("hold in_ready", {31'h0, in_ready_w[0]}, 32'h0);
        end
        in_valid_v[0] = 1'b0;
      end
      release_k(0);
    end

    run_dir(1, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
    check("chunk16 latency", 32'(lat), 32'd1);
    check("chunk16 sum", dut_sum(1), 32'h0);
    release_k(1);
    run_dir(2, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, lat);
    check("chunk1 latency", 32'(lat), 32'd16);
    check("chunk1 sum", dut_sum(2), 32'h0000_8000);
    check("chunk1 ovf", {31'h0, ovf_w[2]}, 32'h1);
    release_k(2);
    run_dir(3, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
    check("w32 latency", 32'(lat), 32'd4);
    check("w32 sum", dut_sum(3), 32'h0);
    check("w32 cout", {31'h0, cout_w[3]}, 32'h1);
    release_k(3);

    a_v[0] = 32'h1234; b_v[0] = 32'h1111; sub_v[0] = 1'b0; cin_v[0] = 1'b0;
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort out_valid", {31'h0, out_valid_w[0]}, 32'h0);
    check("abort sum", dut_sum(0), 32'h0);
    check("abort busy", {31'h0, busy_w[0]}, 32'h0);
    check("abort in_ready", {31'h0, in_ready_w[0]}, 32'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_dir(0, 32'h0000_00FF, 32'h0000_0F01, 1'b0, 1'b0, lat);
    check("post-reset latency", 32'(lat), 32'd4);
    check("post-reset sum", dut_sum(0), 32'h0000_1000);
    release_k(0);

    fork
      rand_ops(0, 250);
      rand_ops(1, 250);
      rand_ops(2, 250);
      rand_ops(3, 250);
    join
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
